// File: rtl/cw_envelope_shaper.sv
// cw_envelope_shaper
// Keyed CW envelope generator for the transmitter's CORDIC NCO.
// The key is synchronised, then a ramp index r (0..2^STEP_BITS) is stepped by a
// prescaled tick to form a linear attack/decay. CW_RF = clamped level * r / 2^STEP_BITS.
// CW_PTT is held through a programmable hang time after the decay finishes.
module cw_envelope_shaper #(
    parameter int STEP_BITS  = 8,
    parameter int HANG_SHIFT = 16
) (
    input  logic        clk,
    input  logic        reset,        // asynchronous, active low
    input  logic        cw_key,
    input  logic        cw_enable,
    input  logic [15:0] cw_level,
    input  logic [15:0] cw_ramp_div,
    input  logic [9:0]  hang_ticks,
    output logic [15:0] CW_RF,
    output logic        CW_PTT,
    output logic        cw_busy
);

    localparam int R_W    = STEP_BITS + 1;
    localparam int PROD_W = 15 + R_W;
    localparam logic [R_W-1:0] R_MAX = {1'b1, {STEP_BITS{1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RAMP_UP,
        ST_ON,
        ST_RAMP_DOWN,
        ST_HANG
    } state_t;

    state_t                 state_reg, state_next;
    logic [1:0]             sync_reg;
    logic [R_W-1:0]         r_reg, r_next;
    logic [15:0]            pre_reg, pre_next;
    logic [HANG_SHIFT-1:0]  hang_pre_reg, hang_pre_next;
    logic [9:0]             hang_cnt_reg, hang_cnt_next;
    logic [15:0]            rf_next;
    logic [14:0]            lvl;
    logic                   key_s;
    logic                   ramp_tick;
    logic                   hang_tick;
    logic                   state_change;

    // Two-flop synchroniser for the asynchronous key input
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_reg <= 2'b00;
        end else begin
            sync_reg <= {sync_reg[0], cw_key};
        end
    end

    // Enable is applied after the synchroniser so dropping it acts like a key release
    assign key_s = sync_reg[1] & cw_enable;

    // A live cw_ramp_div lowered below the running count still produces a tick
    // instead of waiting for the 16-bit counter to wrap.
    assign ramp_tick = (pre_reg >= cw_ramp_div);
    assign hang_tick = &hang_pre_reg;

    // Next-state, ramp index and hang counter; key transitions take priority over ticks
    always_comb begin
        state_next    = state_reg;
        r_next        = r_reg;
        hang_cnt_next = hang_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                r_next = '0;
                if (key_s) begin
                    state_next = ST_RAMP_UP;
                end
            end
            ST_RAMP_UP: begin
                if (!key_s) begin
                    state_next = ST_RAMP_DOWN;
                end else if (r_reg == R_MAX) begin
                    state_next = ST_ON;
                end else if (ramp_tick) begin
                    r_next = r_reg + 1'b1;
                end
            end
            ST_ON: begin
                r_next = R_MAX;
                if (!key_s) begin
                    state_next = ST_RAMP_DOWN;
                end
            end
            ST_RAMP_DOWN: begin
                if (key_s) begin
                    state_next = ST_RAMP_UP;
                end else if (r_reg == '0) begin
                    if (hang_ticks == '0) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next    = ST_HANG;
                        hang_cnt_next = hang_ticks;
                    end
                end else if (ramp_tick) begin
                    r_next = r_reg - 1'b1;
                end
            end
            ST_HANG: begin
                r_next = '0;
                if (key_s) begin
                    state_next = ST_RAMP_UP;
                end else if (hang_tick) begin
                    // Leaving on the final tick rather than one cycle after the
                    // counter reads zero keeps the hang exactly hang_ticks long.
                    if (hang_cnt_reg <= 10'd1) begin
                        state_next = ST_IDLE;
                    end else begin
                        hang_cnt_next = hang_cnt_reg - 10'd1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                r_next     = '0;
            end
        endcase
    end

    // Prescalers restart on every state change so each phase begins with a full step period
    always_comb begin
        state_change  = (state_next != state_reg);
        pre_next      = (state_change || ramp_tick) ? 16'd0 : pre_reg + 16'd1;
        hang_pre_next = state_change ? '0 : hang_pre_reg + 1'b1;
    end

    // Amplitude: clamp to positive 15-bit range, scale by r / 2^STEP_BITS
    always_comb begin
        lvl     = cw_level[15] ? 15'h7FFF : cw_level[14:0];
        rf_next = 16'((PROD_W'(lvl) * PROD_W'(r_reg)) >> STEP_BITS);
    end

    // State, ramp and hang registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            r_reg        <= '0;
            pre_reg      <= '0;
            hang_pre_reg <= '0;
            hang_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            r_reg        <= r_next;
            pre_reg      <= pre_next;
            hang_pre_reg <= hang_pre_next;
            hang_cnt_reg <= hang_cnt_next;
        end
    end

    // Output stage: CW_RF and CW_PTT share one pipeline register so PTT brackets RF
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            CW_RF  <= '0;
            CW_PTT <= 1'b0;
        end else begin
            CW_RF  <= rf_next;
            CW_PTT <= (state_reg != ST_IDLE);
        end
    end

    assign cw_busy = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_cw_envelope_shaper.sv
// tb_cw_envelope_shaper
// Directed scenarios followed by randomized keying, checked every cycle against
// a cycle-level behavioural model of the envelope (mode, ramp index, hang in cycles).
module tb_cw_envelope_shaper;

    localparam int SB   = 8;
    localparam int HS   = 4;
    localparam int RMAX = 1 << SB;

    localparam int M_IDLE = 0;
    localparam int M_UP   = 1;
    localparam int M_ON   = 2;
    localparam int M_DOWN = 3;
    localparam int M_HANG = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cw_key;
    logic        cw_enable;
    logic [15:0] cw_level;
    logic [15:0] cw_ramp_div;
    logic [9:0]  hang_ticks;
    logic [15:0] CW_RF;
    logic        CW_PTT;
    logic        cw_busy;

    int checks   = 0;
    int failures = 0;

    // model state
    int m_mode, m_r, m_since, m_hang_left, m_rf;
    bit m_s1, m_s2, m_ptt;

    cw_envelope_shaper #(.STEP_BITS(SB), .HANG_SHIFT(HS)) dut (
        .clk        (clk),
        .reset      (reset),
        .cw_key     (cw_key),
        .cw_enable  (cw_enable),
        .cw_level   (cw_level),
        .cw_ramp_div(cw_ramp_div),
        .hang_ticks (hang_ticks),
        .CW_RF      (CW_RF),
        .CW_PTT     (CW_PTT),
        .cw_busy    (cw_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_mode = M_IDLE; m_r = 0; m_since = 0; m_hang_left = 0;
        m_rf = 0; m_ptt = 0; m_s1 = 0; m_s2 = 0;
    endtask

    // One clock edge of the reference envelope, using inputs as sampled at the edge
    task automatic model_edge();
        bit keyed, tick;
        int lvl, nm;
        if (!reset) begin
            model_reset();
            return;
        end
        keyed = m_s2 && cw_enable;
        lvl   = (int'(cw_level) > 32767) ? 32767 : int'(cw_level);
        m_rf  = (lvl * m_r) / RMAX;
        m_ptt = (m_mode != M_IDLE);
        tick  = (m_since >= int'(cw_ramp_div));
        nm    = m_mode;
        case (m_mode)
            M_IDLE: if (keyed) nm = M_UP;
            M_UP: begin
                if (!keyed) nm = M_DOWN;
                else if (m_r == RMAX) nm = M_ON;
                else if (tick) m_r = m_r + 1;
            end
            M_ON: if (!keyed) nm = M_DOWN;
            M_DOWN: begin
                if (keyed) nm = M_UP;
                else if (m_r == 0) begin
                    if (hang_ticks == 0) nm = M_IDLE;
                    else begin
                        nm = M_HANG;
                        m_hang_left = int'(hang_ticks) * (1 << HS);
                    end
                end else if (tick) m_r = m_r - 1;
            end
            default: begin
                if (keyed) nm = M_UP;
                else begin
                    m_hang_left = m_hang_left - 1;
                    if (m_hang_left == 0) nm = M_IDLE;
                end
            end
        endcase
        if (nm != m_mode || tick) m_since = 0;
        else m_since = m_since + 1;
        m_mode = nm;
        m_s2 = m_s1;
        m_s1 = cw_key;
    endtask

    task automatic expect_val(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s t=%0t observed=%0d expected=%0d", tag, $time, got, exp);
        end
    endtask

    task automatic check_outputs();
        checks++;
        assert (int'(CW_RF) === m_rf) else begin
            failures++;
            $error("FAIL model_rf t=%0t observed=%0d expected=%0d", $time, CW_RF, m_rf);
        end
        checks++;
        assert (CW_PTT === m_ptt) else begin
            failures++;
            $error("FAIL model_ptt t=%0t observed=%0d expected=%0d", $time, CW_PTT, m_ptt);
        end
        checks++;
        assert (cw_busy === (m_mode != M_IDLE)) else begin
            failures++;
            $error("FAIL model_busy t=%0t observed=%0d expected=%0d", $time, cw_busy, m_mode != M_IDLE);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run_until_rf(input int target, input int limit, input string tag);
        int n;
        n = 0;
        while (int'(CW_RF) != target && n < limit) begin
            cycle();
            n++;
        end
        expect_val(tag, int'(CW_RF), target);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((CW_PTT || cw_busy) && n < 3000) begin
            cycle();
            n++;
        end
        expect_val("drain_ptt", int'(CW_PTT), 0);
        expect_val("drain_busy", int'(cw_busy), 0);
    endtask

    // Asynchronous reset applied between clock edges must clear outputs at once
    task automatic async_reset(input int hold);
        #2 reset = 1'b0;
        model_reset();
        #1;
        expect_val("rst_rf", int'(CW_RF), 0);
        expect_val("rst_ptt", int'(CW_PTT), 0);
        expect_val("rst_busy", int'(cw_busy), 0);
        for (int i = 0; i < hold; i++) cycle();
        reset = 1'b1;
    endtask

    initial begin
        int n, prev, cur, cnt, diff;
        reset       = 1'b0;
        cw_key      = 1'b0;
        cw_enable   = 1'b1;
        cw_level    = 16'd16000;
        cw_ramp_div = 16'd0;
        hang_ticks  = 10'd0;
        model_reset();
        #2;
        expect_val("init_rf", int'(CW_RF), 0);
        expect_val("init_ptt", int'(CW_PTT), 0);
        expect_val("init_busy", int'(cw_busy), 0);
        for (int i = 0; i < 3; i++) cycle();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) cycle();

        // Full element, div=0, level=16000, no hang
        cw_key = 1'b1;
        for (int k = 1; k <= 1000; k++) begin
            cycle();
            if (k == 3)   expect_val("ptt_before", int'(CW_PTT), 0);
            if (k == 4)   expect_val("ptt_rise", int'(CW_PTT), 1);
            if (k == 5)   expect_val("rf_step1", int'(CW_RF), 62);
            if (k == 6)   expect_val("rf_step2", int'(CW_RF), 125);
            if (k == 259) expect_val("rf_r255", int'(CW_RF), 15937);
            if (k == 260) expect_val("rf_top", int'(CW_RF), 16000);
        end
        cw_key = 1'b0;
        n = 0;
        while (CW_RF != 16'd0 && n < 600) begin
            cycle();
            n++;
        end
        expect_val("fall_reached", int'(CW_RF), 0);
        expect_val("ptt_at_rf0", int'(CW_PTT), 1);
        cycle();
        expect_val("ptt_drop", int'(CW_PTT), 0);
        drain();

        // Reset mid-ramp with key held; ramp must restart from zero
        cw_key = 1'b1;
        for (int i = 0; i < 50; i++) cycle();
        async_reset(3);
        for (int k = 1; k <= 5; k++) begin
            cycle();
            if (k == 3) expect_val("rst_ptt_before", int'(CW_PTT), 0);
            if (k == 4) expect_val("rst_ptt_rise", int'(CW_PTT), 1);
            if (k == 5) expect_val("rst_restart_rf", int'(CW_RF), 62);
        end
        cw_key = 1'b0;
        drain();

        // Reversal: release at 6250, re-press at 2500
        cw_key = 1'b1;
        run_until_rf(6250, 400, "rev_up_reached");
        cw_key = 1'b0;
        prev = int'(CW_RF);
        for (int i = 1; i <= 200; i++) begin
            cycle();
            cur  = int'(CW_RF);
            diff = (cur > prev) ? cur - prev : prev - cur;
            expect_val("rev_step_dn", int'(diff <= 63), 1);
            if (i > 4) expect_val("rev_dn_mono", int'(cur <= prev), 1);
            prev = cur;
            if (i > 4 && cur <= 2500) break;
        end
        expect_val("rev_dn_reached", prev, 2500);
        cw_key = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            cycle();
            cur  = int'(CW_RF);
            diff = (cur > prev) ? cur - prev : prev - cur;
            expect_val("rev_step_up", int'(diff <= 63), 1);
            if (i > 4) expect_val("rev_up_mono", int'(cur > prev), 1);
            prev = cur;
        end
        run_until_rf(16000, 400, "rev_top_reached");
        cw_key = 1'b0;
        drain();

        // Hang time: 3 ticks of 16 cycles
        hang_ticks = 10'd3;
        cw_key = 1'b1;
        for (int i = 0; i < 300; i++) cycle();
        cw_key = 1'b0;
        run_until_rf(0, 600, "hang_rf0");
        cnt = 0;
        while (CW_PTT && cnt < 200) begin
            cycle();
            cnt++;
        end
        expect_val("hang_len", int'(cnt >= 47 && cnt <= 49), 1);
        drain();
        // Re-press during hang: PTT must not drop
        cw_key = 1'b1;
        for (int i = 0; i < 100; i++) cycle();
        cw_key = 1'b0;
        run_until_rf(0, 600, "hang2_rf0");
        for (int i = 0; i < 20; i++) cycle();
        cw_key = 1'b1;
        for (int i = 0; i < 60; i++) begin
            cycle();
            expect_val("hang_hold_ptt", int'(CW_PTT), 1);
        end
        cw_key = 1'b0;
        drain();

        // Divider and clamp
        hang_ticks  = 10'd0;
        cw_ramp_div = 16'd3;
        cw_level    = 16'hFFFF;
        cw_key      = 1'b1;
        n = 0;
        while (CW_RF == 16'd0 && n < 50) begin
            cycle();
            n++;
        end
        expect_val("div_first_step", int'(CW_RF), 127);
        prev = int'(CW_RF);
        cnt = 0;
        while (int'(CW_RF) == prev && cnt < 50) begin
            cycle();
            cnt++;
        end
        expect_val("div_period", cnt, 4);
        n = 0;
        while (CW_RF != 16'd32767 && n < 2000) begin
            cycle();
            expect_val("no_sign_bit", int'(CW_RF[15]), 0);
            n++;
        end
        expect_val("clamp_top", int'(CW_RF), 32767);
        cw_key = 1'b0;
        drain();

        // Enable dropped while ON, then key toggled while disabled
        cw_ramp_div = 16'd0;
        cw_level    = 16'd16000;
        hang_ticks  = 10'd2;
        cw_key      = 1'b1;
        run_until_rf(16000, 400, "en_top");
        cw_enable = 1'b0;
        run_until_rf(0, 600, "en_down");
        drain();
        for (int i = 0; i < 100; i++) begin
            cw_key = 1'($urandom_range(0, 1));
            cycle();
            expect_val("dis_rf", int'(CW_RF), 0);
            expect_val("dis_ptt", int'(CW_PTT), 0);
        end
        cw_key    = 1'b0;
        cw_enable = 1'b1;
        for (int i = 0; i < 5; i++) cycle();

        // Randomized keying against the reference model
        for (int ep = 0; ep < 60; ep++) begin
            cw_level    = 16'($urandom);
            cw_ramp_div = 16'($urandom_range(0, 3));
            hang_ticks  = 10'($urandom_range(0, 2));
            cw_enable   = ($urandom_range(0, 9) != 0);
            cw_key      = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 14) == 0) async_reset($urandom_range(1, 3));
            n = $urandom_range(1, 400);
            for (int i = 0; i < n; i++) cycle();
        end
        cw_key = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
